dequantization: RTL and testbench



---
 rtl/dequantization.sv | 108 ++++++++++
 tb/tb_dequantization.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantization.sv
// Read-side dequantizer: fetches a packed 8-bit SRAM word, picks one 256-bit slot, and
// expands 32 bytes into 32 signed 32-bit lanes behind a credit-protected output FIFO.
module dequantization #(
    parameter int unsigned       SRAMC_W = 1024,
    parameter int unsigned       ADRC_W  = 12,
    parameter logic signed [31:0] D_SCALE = 32'sd16777216,
    parameter int unsigned       D_SHIFT = 0,
    parameter logic signed [15:0] Z_DEF   = 16'sd128,
    parameter int unsigned       FIFO_D  = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_rd_req,
    input  logic [ADRC_W-1:0]  i_rd_addr,
    output logic               o_rd_ready,
    output logic               o_sramc_rden_q,
    output logic [ADRC_W-1:0]  o_sramc_addr_q,
    input  logic [SRAMC_W-1:0] i_sramc_rdata_q,
    output logic               o_data_valid,
    output logic [SRAMC_W-1:0] o_data,
    input  logic               i_data_ready
);

    localparam int unsigned SLOT_W = SRAMC_W / 4;
    localparam int unsigned LANES  = SLOT_W / 8;
    localparam int unsigned PW     = $clog2(FIFO_D);
    localparam int unsigned CW     = $clog2(FIFO_D + 1);
    localparam int unsigned SW     = $clog2(FIFO_D + 4) + 1;
    localparam logic signed [49:0] RND  = 50'((64'd1 << D_SHIFT) >> 1);
    localparam logic signed [49:0] MAXV = 50'sd2147483647;
    localparam logic signed [49:0] MINV = -50'sd2147483648;

    logic               v0, v1, v2;
    logic [1:0]         slot0;
    logic signed [16:0] d1 [LANES];
    logic signed [48:0] p2 [LANES];
    logic [SRAMC_W-1:0] mem [FIFO_D];
    logic [PW-1:0]      wptr, rptr;
    logic [CW-1:0]      cnt;
    logic               acc, pop, push;
    logic [1:0]         inflight;
    logic [SW-1:0]      need;
    logic [SLOT_W-1:0]  slot_data;
    logic [SRAMC_W-1:0] res_c;

    // Round-half-up, arithmetic shift, then clamp to the signed 32-bit range.
    function automatic logic [31:0] finish_lane(input logic signed [48:0] p);
        logic signed [49:0] r;
        r = (50'(p) + RND) >>> D_SHIFT;
        if (r > MAXV) return 32'h7FFF_FFFF;
        if (r < MINV) return 32'h8000_0000;
        return r[31:0];
    endfunction

    // Credit counts everything that will eventually occupy a FIFO slot.
    assign inflight       = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
    assign pop            = o_data_valid & i_data_ready;
    assign push           = v2;
    assign need           = SW'(inflight) + SW'(cnt) - SW'(pop);
    assign o_rd_ready     = i_rstn & (need < SW'(FIFO_D));
    assign acc            = i_rd_req & o_rd_ready;
    assign o_sramc_rden_q = acc;
    assign o_sramc_addr_q = acc ? (i_rd_addr >> 2) : '0;
    assign o_data_valid   = (cnt != '0);
    assign o_data         = o_data_valid ? mem[rptr] : '0;

    always_comb begin
        slot_data = i_sramc_rdata_q[int'(slot0) * SLOT_W +: SLOT_W];
    end

    always_comb begin
        res_c = '0;
        for (int j = 0; j < LANES; j++) begin
            res_c[j*32 +: 32] = finish_lane(p2[j]);
        end
    end

    // Datapath registers carry no reset; their valid bits gate all use.
    always_ff @(posedge i_clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (v0) d1[j] <= 17'($signed({1'b0, slot_data[j*8 +: 8]})) - 17'(Z_DEF);
            if (v1) p2[j] <= 49'(d1[j]) * 49'(D_SCALE);
        end
        if (push) mem[wptr] <= res_c;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            v0    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            slot0 <= '0;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
        end else begin
            v0 <= acc;
            v1 <= v0;
            v2 <= v1;
            if (acc)  slot0 <= i_rd_addr[1:0];
            if (push) wptr  <= wptr + PW'(1);
            if (pop)  rptr  <= rptr + PW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_dequantization.sv
// Bench for dequantization: three parameterisations share one request stream and SRAM model.
module tb_dequantization;
    localparam int unsigned W = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, req, data_ready;
    logic [11:0]   addr;
    logic [W-1:0]  rdata;
    logic          rdy0, rdy1, rdy2, rden0, rden1, rden2, v0, v1, v2;
    logic [11:0]   sa0, sa1, sa2;
    logic [W-1:0]  d0, d1, d2;
    logic [W-1:0]  sram_mem [16];

    typedef struct { logic [W-1:0] e0, e1, e2; logic [11:0] a; } sb_t;
    typedef struct { logic [11:0] a; logic [7:0] b; logic [31:0] e_def, e_rnd, e_sat; } vec_t;
    sb_t  q[$];
    vec_t vt [8];
    int   total = 0, bad = 0;
    bit   rand_rdy = 1'b0;

    dequantization dut0 (.i_clk(clk), .i_rstn(rstn), .i_rd_req(req), .i_rd_addr(addr),
        .o_rd_ready(rdy0), .o_sramc_rden_q(rden0), .o_sramc_addr_q(sa0), .i_sramc_rdata_q(rdata),
        .o_data_valid(v0), .o_data(d0), .i_data_ready(data_ready));
    dequantization #(.D_SCALE(32'sd3), .D_SHIFT(1)) dut1 (.i_clk(clk), .i_rstn(rstn),
        .i_rd_req(req), .i_rd_addr(addr), .o_rd_ready(rdy1), .o_sramc_rden_q(rden1),
        .o_sramc_addr_q(sa1), .i_sramc_rdata_q(rdata), .o_data_valid(v1), .o_data(d1),
        .i_data_ready(data_ready));
    dequantization #(.D_SCALE(32'sd33554432)) dut2 (.i_clk(clk), .i_rstn(rstn),
        .i_rd_req(req), .i_rd_addr(addr), .o_rd_ready(rdy2), .o_sramc_rden_q(rden2),
        .o_sramc_addr_q(sa2), .i_sramc_rdata_q(rdata), .o_data_valid(v2), .o_data(d2),
        .i_data_ready(data_ready));

    // SRAM model: data one cycle after rden, junk otherwise.
    always @(posedge clk) rdata <= rden0 ? sram_mem[sa0[3:0]] : {32{32'hDEAD_BEEF}};

    function automatic logic [31:0] model(input logic [7:0] b, input longint scale, input int shift);
        longint p;
        p = (longint'(b) - 64'sd128) * scale;
        if (shift > 0) p = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return p[31:0];
    endfunction

    function automatic logic [W-1:0] exp_vec(input logic [11:0] a, input longint scale, input int shift);
        logic [W-1:0] word, r;
        int base;
        word = sram_mem[a[5:2]];
        r = '0;
        for (int j = 0; j < 32; j++) begin
            base = int'(a[1:0]) * 256 + j * 8;
            r[j*32 +: 32] = model(word[base +: 8], scale, shift);
        end
        return r;
    endfunction

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int j = 0; j < 32; j++) begin
                if (act[j*32 +: 32] !== exp[j*32 +: 32]) begin
                    $display("FAIL %s lane=%0d act=%h exp=%h t=%0t", n, j,
                             act[j*32 +: 32], exp[j*32 +: 32], $time);
                    break;
                end
            end
        end
    endtask

    // Scoreboard: expectations pushed on acceptance, compared on every pop.
    always @(negedge clk) begin
        if (rstn) begin
            if (req && rdy0)
                q.push_back('{exp_vec(addr, 16777216, 0), exp_vec(addr, 3, 1),
                              exp_vec(addr, 33554432, 0), addr});
            if (v0 && data_ready) begin
                sb_t e;
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected_output t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    chk_vec("sb_default", d0, e.e0);
                    chk_vec("sb_round", d1, e.e1);
                    chk_vec("sb_saturate", d2, e.e2);
                end
            end
            if (dut0.push && !dut0.pop && dut0.cnt == 3'd4) begin
                bad++;
                $display("FAIL fifo_overflow cnt=%0d exp<4", dut0.cnt);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) data_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [11:0] a, output int waited);
        bit ok;
        waited = 0; req = 1'b1; addr = a;
        forever begin
            @(negedge clk); ok = rdy0;
            if (ok) begin
                chk32("rden", 32'(rden0), 32'd1);
                chk32("sram_addr", 32'(sa0), 32'(a >> 2));
            end
            @(posedge clk); #1;
            if (ok) break;
            waited++;
            if (waited > 200) begin
                total++; bad++;
                $display("FAIL send_timeout addr=%h waited=%0d", a, waited);
                break;
            end
        end
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        forever begin
            @(negedge clk);
            if (v0) break;
            k++;
            if (k > 50) begin
                total++; bad++;
                $display("FAIL valid_timeout waited=%0d", k);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((q.size() != 0 || v0) && c < 300) begin
            @(posedge clk); #1; c++;
        end
        chk32("drain_idle", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int wt, k, idx, c, stale;
        bit ok;
        logic [W-1:0] word;
        rstn = 1'b0; req = 1'b0; addr = '0; data_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 32; j++) sram_mem[i][j*32 +: 32] = $urandom();
        vt = '{'{12'h005, 8'h80, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
               '{12'h000, 8'h00, 32'h8000_0000, 32'hFFFF_FF40, 32'h8000_0000},
               '{12'h00A, 8'hFF, 32'h7F00_0000, 32'h0000_00BF, 32'h7FFF_FFFF},
               '{12'h00F, 8'h81, 32'h0100_0000, 32'h0000_0002, 32'h0200_0000},
               '{12'h004, 8'h7F, 32'hFF00_0000, 32'hFFFF_FFFF, 32'hFE00_0000},
               '{12'h009, 8'hF8, 32'h7800_0000, 32'h0000_00B4, 32'h7FFF_FFFF},
               '{12'h00E, 8'hC0, 32'h4000_0000, 32'h0000_0060, 32'h7FFF_FFFF},
               '{12'h003, 8'h40, 32'hC000_0000, 32'hFFFF_FFA0, 32'h8000_0000}};

        repeat (2) @(posedge clk); #1;
        chk32("rst_valid", 32'(v0), 32'd0);
        chk32("rst_ready", 32'(rdy0), 32'd0);
        chk_vec("rst_data", d0, '0);
        rstn = 1'b1;
        @(negedge clk); chk32("ready_after_rst", 32'(rdy0), 32'd1);
        @(posedge clk); #1;

        // Single-slot fills: target slot holds one byte value, others 0xFF.
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 128; b++)
                word[b*8 +: 8] = ((b / 32) == int'(vt[i].a[1:0])) ? vt[i].b : 8'hFF;
            sram_mem[vt[i].a[5:2]] = word;
            send(vt[i].a, wt);
            req = 1'b0;
            wait_valid(k);
            chk32("latency", 32'(k), 32'd3);
            chk32("vec_default", d0[31:0], vt[i].e_def);
            chk32("vec_round", d1[31:0], vt[i].e_rnd);
            chk32("vec_saturate", d2[31:0], vt[i].e_sat);
            @(posedge clk); #1;
        end

        // Ramp in slot 0: byte j = j*8.
        for (int b = 0; b < 128; b++) word[b*8 +: 8] = (b < 32) ? 8'(b * 8) : 8'hFF;
        sram_mem[4] = word;
        send(12'h010, wt);
        req = 1'b0;
        wait_valid(k);
        chk32("ramp_lane0", d0[31:0], 32'h8000_0000);
        chk32("ramp_lane16", d0[16*32 +: 32], 32'h0000_0000);
        chk32("ramp_lane31", d0[31*32 +: 32], 32'h7800_0000);
        @(posedge clk); #1;
        wait_idle();

        // Backpressure: only FIFO_D requests fit while the consumer stalls.
        data_ready = 1'b0; req = 1'b1; idx = 0;
        for (int cy = 0; cy < 10; cy++) begin
            addr = 12'(idx);
            @(negedge clk); ok = rdy0;
            @(posedge clk); #1;
            if (ok) idx++;
        end
        chk32("bp_accepted", 32'(idx), 32'd4);
        @(negedge clk); chk32("bp_ready_low", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        data_ready = 1'b1; c = 0;
        while (idx < 8 && c < 50) begin
            addr = 12'(idx);
            @(negedge clk); ok = rdy0;
            @(posedge clk); #1;
            if (ok) idx++;
            c++;
        end
        req = 1'b0;
        chk32("bp_refill_cycles", 32'(c), 32'd4);
        wait_idle();

        // Random traffic with a jittery consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) send(12'($urandom_range(0, 63)), wt);
        req = 1'b0; rand_rdy = 1'b0; data_ready = 1'b1;
        wait_idle();

        // Asynchronous reset with three requests in flight.
        send(12'h020, wt); send(12'h021, wt); send(12'h022, wt);
        addr = 12'h02F;
        rstn = 1'b0;
        q.delete();
        #1;
        chk32("midrst_valid", 32'(v0), 32'd0);
        chk_vec("midrst_data", d0, '0);
        chk32("midrst_rden", 32'(rden0), 32'd0);
        chk32("midrst_addr", 32'(sa0), 32'd0);
        chk32("midrst_ready", 32'(rdy0), 32'd0);
        repeat (2) @(posedge clk); #1;
        req = 1'b0; rstn = 1'b1;
        @(negedge clk); chk32("postrst_ready", 32'(rdy0), 32'd1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (v0) stale++;
        end
        chk32("postrst_no_stale", 32'(stale), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
